// File: rtl/mem_block_responder_pkg.sv
// rtl/mem_block_responder_pkg.sv - shared types and constants for the block responder
package mem_pkg;

  localparam int ADDR_W          = 10;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int NUM_BLOCKS      = 64;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
  localparam int IDX_W           = 6;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0]                   blk_idx_t;
  typedef logic [BLOCK_W-1:0]                 block_t;
  typedef logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] store_t;

  // Power-up contents of one block: word n of the store holds the value n.
  function automatic block_t init_block(blk_idx_t idx);
    block_t b;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      b[w*WORD_W +: WORD_W] = WORD_W'({idx, 2'(w)});
    end
    return b;
  endfunction

  function automatic store_t init_store();
    store_t s;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      s[b] = init_block(blk_idx_t'(b));
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// rtl/mem_block_responder_if.sv - cache-to-memory block request interface
interface mem_block_responder_if;
  import mem_pkg::*;

  logic                mem_req;
  logic                mem_rw;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BLOCK_W-1:0]  mem_wdata;
  logic                mem_ready;
  logic                mem_busy;
  logic [BLOCK_W-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_rw, mem_addr, mem_wdata,
    input  mem_ready, mem_busy, mem_rdata
  );

  modport slave (
    input  mem_req, mem_rw, mem_addr, mem_wdata,
    output mem_ready, mem_busy, mem_rdata
  );

endinterface

// File: rtl/mem_block_responder_array.sv
// rtl/mem_block_responder_array.sv - 64 x 128 backing store, sync write, comb read
module mem_block_array
  import mem_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  blk_idx_t waddr,
  input  block_t   wdata,
  input  blk_idx_t raddr,
  output block_t   rdata
);

  // Contents survive reset; only the power-up image is defined.
  store_t store = init_store();

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      store[waddr] <= wdata;
    end
  end

  assign rdata = store[raddr];

endmodule

// File: rtl/mem_block_responder.sv
// rtl/mem_block_responder.sv - fixed-latency block fill / write-back responder
module mem_block_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_block_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rw_q;
  blk_idx_t         blk_q;
  block_t           wdata_q;
  logic             ready_q;
  logic             busy_q;
  block_t           rdata_q;
  block_t           arr_rdata;
  logic             commit;
  logic             unused_addr_bits;

  // The request finishes on the BUSY edge where the counter has run out.
  assign commit           = (state == BUSY) && (cnt == '0);
  assign unused_addr_bits = ^bus.mem_addr[3:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; inputs only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.mem_req) state_nxt = BUSY;
      BUSY:    if (cnt == '0)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance and count down the latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rw_q    <= 1'b0;
      blk_q   <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && bus.mem_req) begin
      cnt     <= CNT_LOAD;
      rw_q    <= bus.mem_rw;
      blk_q   <= bus.mem_addr[9:4];
      wdata_q <= bus.mem_wdata;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_nxt == DONE);
      busy_q  <= (state_nxt != IDLE);
      if (commit && !rw_q) begin
        rdata_q <= arr_rdata;
      end
    end
  end

  mem_block_array u_array (
    .clk   (clk),
    .we    (commit && rw_q),
    .waddr (blk_q),
    .wdata (wdata_q),
    .raddr (blk_q),
    .rdata (arr_rdata)
  );

  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// tb/tb_mem_block_responder.sv - scoreboard bench for mem_block_responder
module tb_mem_block_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, rw_s;
  logic [9:0]   addr_s;
  logic [127:0] wdata_s;
  int           checks = 0;
  int           errors = 0;
  logic [127:0] model [64];
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  mem_block_responder_if if0 ();
  mem_block_responder_if if1 ();

  assign if0.mem_req   = req0;
  assign if0.mem_rw    = rw_s;
  assign if0.mem_addr  = addr_s;
  assign if0.mem_wdata = wdata_s;
  assign if1.mem_req   = req1;
  assign if1.mem_rw    = rw_s;
  assign if1.mem_addr  = addr_s;
  assign if1.mem_wdata = wdata_s;

  mem_block_responder #(.LATENCY(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mem_block_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  function automatic logic [127:0] init_blk(int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = 32'(4*b + w);
    return r;
  endfunction

  function automatic logic [127:0] exp_blk(bit sel, logic [9:0] a);
    return sel ? init_blk(int'(a[9:4])) : model[a[9:4]];
  endfunction

  function automatic logic get_ready(bit sel);
    return sel ? if1.mem_ready : if0.mem_ready;
  endfunction

  function automatic logic get_busy(bit sel);
    return sel ? if1.mem_busy : if0.mem_busy;
  endfunction

  function automatic logic [127:0] get_rdata(bit sel);
    return sel ? if1.mem_rdata : if0.mem_rdata;
  endfunction

  task automatic set_req(bit sel, logic v);
    if (sel) req1 = v; else req0 = v;
  endtask

  task automatic start_req(bit sel, bit rw, logic [9:0] a, logic [127:0] wd);
    @(negedge clk);
    rw_s = rw; addr_s = a; wdata_s = wd;
    set_req(sel, 1'b1);
    if (!rw) sb.push_back(exp_blk(sel, a));
  endtask

  task automatic wait_ready(input bit sel, input int chg_at, input logic [9:0] a2,
                            input logic [127:0] wd2, output int n, output int busy_n,
                            output bit to);
    n = 0; busy_n = 0; to = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == chg_at) begin addr_s = a2; wdata_s = wd2; end
      if (get_busy(sel)) busy_n++;
      if (get_ready(sel)) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rw_s = 1'b0; addr_s = '0; wdata_s = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({get_ready(s[0]), get_busy(s[0])} !== 2'b00) begin
        errors++; $display("FAIL reset_ctrl dut%0d got %b exp 00", s, {get_ready(s[0]), get_busy(s[0])});
      end
      checks++;
      if (get_rdata(s[0]) !== 128'h0) begin
        errors++; $display("FAIL reset_rdata dut%0d got %h exp 0", s, get_rdata(s[0]));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_latency();
    int n, bn; bit to; logic [127:0] exp;
    start_req(1'b0, 1'b0, 10'h000, '0);
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    checks++;
    if (to || n - 1 != 4) begin errors++; $display("FAIL read_latency got %0d exp 4 (timeout %0d)", n - 1, to); end
    checks++;
    if (bn != 5) begin errors++; $display("FAIL read_busy_cycles got %0d exp 5", bn); end
    exp = sb.pop_front();
    checks++;
    if (get_rdata(1'b0) !== exp || exp !== 128'h00000003_00000002_00000001_00000000) begin
      errors++; $display("FAIL read_000_data got %h exp %h", get_rdata(1'b0), exp);
    end
    @(negedge clk);
    checks++;
    if ({get_ready(1'b0), get_busy(1'b0)} !== 2'b00) begin
      errors++; $display("FAIL read_after_done got %b exp 00", {get_ready(1'b0), get_busy(1'b0)});
    end
  endtask

  task automatic test_write_read();
    int n, bn; bit to; logic [127:0] wd, exp;
    wd = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    start_req(1'b0, 1'b1, 10'h3F0, wd);
    model[63] = wd;
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    checks++;
    if (to || n - 1 != 4) begin errors++; $display("FAIL write_latency got %0d exp 4", n - 1); end
    @(negedge clk);
    checks++;
    if (get_ready(1'b0) !== 1'b0) begin errors++; $display("FAIL write_ready_width got 1 exp 0"); end
    start_req(1'b0, 1'b0, 10'h3FC, '0);
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(1'b0) !== exp || exp !== wd) begin
      errors++; $display("FAIL write_then_read got %h exp %h", get_rdata(1'b0), wd);
    end
  endtask

  task automatic test_back_to_back(bit sel, logic [9:0] a1, logic [9:0] a2, int exp_gap);
    int n, bn; bit to; logic [127:0] exp;
    start_req(sel, 1'b0, a1, '0);
    wait_ready(sel, 0, '0, '0, n, bn, to);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(sel) !== exp) begin
      errors++; $display("FAIL b2b_first dut%0d got %h exp %h", sel, get_rdata(sel), exp);
    end
    addr_s = a2;
    sb.push_back(exp_blk(sel, a2));
    @(negedge clk);
    checks++;
    if (get_busy(sel) !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap dut%0d got busy 1 exp 0", sel); end
    @(negedge clk);
    checks++;
    if (get_busy(sel) !== 1'b1) begin errors++; $display("FAIL b2b_second_accept dut%0d got busy 0 exp 1", sel); end
    set_req(sel, 1'b0);
    wait_ready(sel, 0, '0, '0, n, bn, to);
    checks++;
    if (to || n + 2 != exp_gap) begin errors++; $display("FAIL b2b_period dut%0d got %0d exp %0d", sel, n + 2, exp_gap); end
    exp = sb.pop_front();
    checks++;
    if (get_rdata(sel) !== exp) begin
      errors++; $display("FAIL b2b_second dut%0d got %h exp %h", sel, get_rdata(sel), exp);
    end
  endtask

  task automatic test_mid_busy_change();
    int n, bn; bit to; logic [127:0] exp, wx;
    start_req(1'b0, 1'b0, 10'h050, '0);
    wait_ready(1'b0, 2, 10'h060, {4{32'hDEADBEEF}}, n, bn, to);
    set_req(1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(1'b0) !== exp) begin errors++; $display("FAIL mid_busy_read got %h exp %h", get_rdata(1'b0), exp); end
    wx = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
    start_req(1'b0, 1'b1, 10'h070, wx);
    model[7] = wx;
    wait_ready(1'b0, 2, 10'h080, {4{32'h0BAD_0BAD}}, n, bn, to);
    set_req(1'b0, 1'b0);
    start_req(1'b0, 1'b0, 10'h070, '0);
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(1'b0) !== exp) begin errors++; $display("FAIL mid_busy_write got %h exp %h", get_rdata(1'b0), exp); end
    start_req(1'b0, 1'b0, 10'h080, '0);
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(1'b0) !== exp) begin errors++; $display("FAIL mid_busy_untouched got %h exp %h", get_rdata(1'b0), exp); end
  endtask

  task automatic test_reset_abort();
    int n, bn; bit to; logic [127:0] exp;
    start_req(1'b0, 1'b1, 10'h100, {4{32'hFFFF_0000}});
    @(negedge clk);
    set_req(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({get_ready(1'b0), get_busy(1'b0)} !== 2'b00 || get_rdata(1'b0) !== 128'h0) begin
      errors++; $display("FAIL abort_outputs got %b/%h exp 00/0", {get_ready(1'b0), get_busy(1'b0)}, get_rdata(1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_req(1'b0, 1'b0, 10'h100, '0);
    wait_ready(1'b0, 0, '0, '0, n, bn, to);
    set_req(1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (to || get_rdata(1'b0) !== exp || exp !== init_blk(16)) begin
      errors++; $display("FAIL abort_no_commit got %h exp %h", get_rdata(1'b0), init_blk(16));
    end
  endtask

  task automatic test_latency1();
    int n, bn; bit to; logic [127:0] exp;
    start_req(1'b1, 1'b0, 10'h040, '0);
    wait_ready(1'b1, 0, '0, '0, n, bn, to);
    set_req(1'b1, 1'b0);
    checks++;
    if (to || n - 1 != 1 || bn != 2) begin
      errors++; $display("FAIL lat1_timing got lat %0d busy %0d exp 1/2", n - 1, bn);
    end
    exp = sb.pop_front();
    checks++;
    if (get_rdata(1'b1) !== exp) begin errors++; $display("FAIL lat1_data got %h exp %h", get_rdata(1'b1), exp); end
    test_back_to_back(1'b1, 10'h0A0, 10'h0B0, 3);
  endtask

  initial begin
    for (int b = 0; b < 64; b++) model[b] = init_blk(b);
    test_reset();
    test_read_latency();
    test_write_read();
    test_back_to_back(1'b0, 10'h010, 10'h020, 6);
    test_mid_busy_change();
    test_reset_abort();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Main-memory responder for the write-back data cache. It accepts one block request at a time from the cache controller: a block fill (read) or a dirty-block write-back (write). It serves each request after a fixed, parameterised latency and signals completion with a one-cycle ready pulse. It sits between the cache's memory-side port and the 1 KiB backing store, which it owns.

## Interface
- `LATENCY`, default 4: edges from request acceptance to ready. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` in 1: request valid. Sampled only in IDLE.
- `mem_rw` in 1: 0 = block read (fill), 1 = block write (write-back).
- `mem_addr` in 10: byte address. Block index is `mem_addr[9:4]`; `[3:0]` is ignored.
- `mem_wdata` in 128: write block. Word 0 is in `[31:0]` and word 3 is in `[127:96]`.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_busy` out 1: high in BUSY and DONE.
- `mem_rdata` out 128: read block. Holds its value until the next read completes.

## Operation
- States are IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE with `mem_req`=1:
  - latch `mem_rw`, block index and `mem_wdata`;
  - load the counter with LATENCY-1;
  - go to BUSY.
- IDLE with `mem_req`=0: stay in IDLE.
- BUSY with counter ≠ 0: decrement. Counter is 4 bits unsigned and never wraps.
- BUSY with counter = 0: go to DONE. On this same edge:
  - read: `mem_rdata` ← stored block;
  - write: stored block ← latched wdata.
- DONE: `mem_ready`=1 for exactly this cycle, then go to IDLE unconditionally.
- Inputs are ignored in BUSY and DONE. Changing `mem_addr` or `mem_wdata` mid-request has no effect.
- The requester drops `mem_req` in the cycle `mem_ready` is seen. If `mem_req` is still high in the first IDLE cycle, it is treated as a new request (back-to-back).
- Storage is 64 blocks × 128 bits. At time 0, word n (n = 0..255, byte address 4n) holds 32'hn. Reset does not alter storage.
- Reset mid-request: return to IDLE, and the counter and latched request clear. An aborted write does not commit. `mem_rdata` is cleared to 0.
- Write then read of the same block returns the written data; there is no hazard, because commit precedes the next acceptance.

## Timing
- Reset values: `mem_ready`=0, `mem_busy`=0, `mem_rdata`=0, state IDLE, counter 0.
- Acceptance on edge t0 raises `mem_ready` after edge t0+LATENCY, for exactly one cycle.
- `mem_busy` is high from after t0 through the DONE cycle.
- Minimum request period is LATENCY+2 cycles: one IDLE cycle, LATENCY cycles in BUSY, one DONE cycle.
- `mem_rdata` is valid no later than `mem_ready` and is stable until the next read's DONE edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mem_pkg` holds:
  - `ADDR_W`=10, `BLOCK_W`=128, `WORD_W`=32, `NUM_BLOCKS`=64;
  - the state enum {IDLE, BUSY, DONE};
  - `blk_idx_t` (6 bits).
- Sub-module `mem_block_array`: 64×128 storage with one synchronous write port, one combinational read port, and the time-0 initialisation. The responder holds the FSM, the counter and the request latch.

## Test plan
- Reset, then read at 0x000 with LATENCY=4:
  - `mem_ready` pulses exactly 4 edges after acceptance;
  - `mem_rdata`=128'h00000003_00000002_00000001_00000000;
  - `mem_busy` is high for 5 cycles.
- Write at 0x3F0 with data {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, then read at 0x3FC: returns that block. `mem_addr[3:0]` is ignored.
- Back-to-back: hold `mem_req` high across two reads (0x010, then 0x020). The second is accepted in the IDLE cycle after the first DONE.
  - `mem_rdata` = words 4..7, then words 8..11.
- Stimulus changes mid-BUSY: `mem_addr` and `mem_wdata` are altered while busy and must be ignored. The latched request completes unchanged.
- Assert `rst_n` during BUSY of a write to 0x100, then read 0x100:
  - the original words 64..67 are returned;
  - all outputs are 0 during reset.
- LATENCY=1: ready pulses 1 edge after acceptance, and the minimum request period is 3 cycles.
